// File: rtl/chip8_pkg.sv
// chip8_pkg
// Shared definitions for the Chip-8 core: the address-space constants used by
// the RAM, fetch unit and executor, the program-counter flow commands, and the
// fetch sequencer state encoding.
// Ports: none (package).
package chip8_pkg;

  localparam int          CHIP8_ADDR_BITS   = 12;
  localparam logic [11:0] CHIP8_RESET_PC    = 12'h200;
  localparam int          CHIP8_STACK_DEPTH = 16;

  typedef enum logic [2:0] {
    NEXT = 3'd0,
    SKIP = 3'd1,
    JUMP = 3'd2,
    CALL = 3'd3,
    RET  = 3'd4
  } pc_cmd_t;

  typedef enum logic [2:0] {
    FETCH_HI,
    FETCH_LO,
    HOLD,
    WAIT_CMD,
    HALT
  } fetch_state_t;

  // Unassigned command codes (5-7) behave as a plain advance.
  function automatic pc_cmd_t decode_cmd(input logic [2:0] code);
    pc_cmd_t kind;
    case (code)
      3'd1:    kind = SKIP;
      3'd2:    kind = JUMP;
      3'd3:    kind = CALL;
      3'd4:    kind = RET;
      default: kind = NEXT;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/chip8_call_stack.sv
// chip8_call_stack
// Return-address stack for CALL/RET. Holds STACK_DEPTH addresses and a stack
// pointer that counts occupied entries (0..STACK_DEPTH).
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low; empties the stack
//   push       store push_data on top (caller guarantees !full)
//   pop        discard the top entry (caller guarantees !empty)
//   push_data  return address to store
//   top        most recently pushed address (undefined while empty)
//   full       sp == STACK_DEPTH
//   empty      sp == 0
module chip8_call_stack
  import chip8_pkg::*;
#(
  parameter int ADDR_BITS   = CHIP8_ADDR_BITS,
  parameter int STACK_DEPTH = CHIP8_STACK_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [ADDR_BITS-1:0] push_data,
  output logic [ADDR_BITS-1:0] top,
  output logic                 full,
  output logic                 empty
);

  localparam int SP_BITS  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_BITS = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_BITS-1:0] mem [STACK_DEPTH];
  logic [SP_BITS-1:0]   sp;
  logic [SP_BITS-1:0]   top_idx;

  // sp points one past the newest entry, so the top lives at sp-1.
  always_comb begin
    top_idx = sp - 1'b1;
    top     = mem[top_idx[IDX_BITS-1:0]];
    full    = (sp == SP_BITS'(STACK_DEPTH));
    empty   = (sp == '0);
  end

  // Entry storage and pointer update; push and pop are never requested together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[sp[IDX_BITS-1:0]] <= push_data;
      sp                    <= sp + 1'b1;
    end else if (pop) begin
      sp <= sp - 1'b1;
    end
  end

endmodule

// File: rtl/chip8_fetch.sv
// chip8_fetch
// Instruction fetch and program-counter unit. Reads the two opcode bytes at pc
// over the shared RAM bus, presents the big-endian opcode to the decoder on a
// valid/ready handshake, then applies the executor's flow command to pc.
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   bus_req, bus_grant    shared RAM bus request / arbiter grant
//   ram_address           byte address (pc in FETCH_HI, pc+1 in FETCH_LO)
//   ram_select            read enable = bus_req & bus_grant
//   ram_write             always 0
//   ram_data              RAM read data, sampled on the granted edge
//   op_valid, op_ready    opcode handshake
//   opcode, op_pc         presented opcode and its address
//   cmd_valid, cmd        flow command strobe and code (NEXT/SKIP/JUMP/CALL/RET)
//   cmd_target            JUMP/CALL destination
//   pc                    current program counter
//   stack_err             sticky call-stack overflow/underflow; unit halts
module chip8_fetch
  import chip8_pkg::*;
#(
  parameter int                   ADDR_BITS   = CHIP8_ADDR_BITS,
  parameter logic [ADDR_BITS-1:0] RESET_PC    = ADDR_BITS'(CHIP8_RESET_PC),
  parameter int                   STACK_DEPTH = CHIP8_STACK_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 bus_req,
  input  logic                 bus_grant,
  output logic [ADDR_BITS-1:0] ram_address,
  output logic                 ram_select,
  output logic                 ram_write,
  input  logic [7:0]           ram_data,
  output logic                 op_valid,
  input  logic                 op_ready,
  output logic [15:0]          opcode,
  output logic [ADDR_BITS-1:0] op_pc,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd,
  input  logic [ADDR_BITS-1:0] cmd_target,
  output logic [ADDR_BITS-1:0] pc,
  output logic                 stack_err
);

  fetch_state_t         state;
  logic [7:0]           hi;
  logic                 cmd_fire;
  pc_cmd_t              cmd_kind;
  logic [ADDR_BITS-1:0] pc_plus2;
  logic [ADDR_BITS-1:0] pc_next;
  logic                 cmd_err;
  logic                 push;
  logic                 pop;
  logic [ADDR_BITS-1:0] stack_top;
  logic                 stack_full;
  logic                 stack_empty;

  chip8_call_stack #(
    .ADDR_BITS  (ADDR_BITS),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .push_data(pc_plus2),
    .top      (stack_top),
    .full     (stack_full),
    .empty    (stack_empty)
  );

  // Bus-facing outputs decode straight from state; reset is folded into
  // bus_req so the bus stays quiet for as long as reset is held.
  always_comb begin
    bus_req     = reset && ((state == FETCH_HI) || (state == FETCH_LO));
    ram_select  = bus_req && bus_grant;
    ram_address = (state == FETCH_LO) ? pc + ADDR_BITS'(1) : pc;
    ram_write   = 1'b0;
    op_valid    = (state == HOLD);
  end

  // Command evaluation. A command is taken either together with the opcode
  // handshake or later while waiting; a stack fault suppresses push/pop so pc
  // and the stack stay exactly as they were.
  always_comb begin
    cmd_fire = ((state == HOLD) && op_ready && cmd_valid) ||
               ((state == WAIT_CMD) && cmd_valid);
    cmd_kind = decode_cmd(cmd);
    pc_plus2 = pc + ADDR_BITS'(2);
    pc_next  = pc_plus2;
    cmd_err  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    case (cmd_kind)
      SKIP: pc_next = pc + ADDR_BITS'(4);
      JUMP: pc_next = cmd_target;
      CALL: begin
        if (stack_full) begin
          cmd_err = 1'b1;
        end else begin
          pc_next = cmd_target;
          push    = cmd_fire;
        end
      end
      RET: begin
        if (stack_empty) begin
          cmd_err = 1'b1;
        end else begin
          pc_next = stack_top;
          pop     = cmd_fire;
        end
      end
      default: ;
    endcase
  end

  // Fetch sequencer: high byte, low byte, present, then wait for the command.
  // HALT is terminal until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH_HI;
      pc        <= RESET_PC;
      hi        <= '0;
      opcode    <= '0;
      op_pc     <= RESET_PC;
      stack_err <= 1'b0;
    end else begin
      case (state)
        FETCH_HI: begin
          if (bus_grant) begin
            hi    <= ram_data;
            state <= FETCH_LO;
          end
        end
        FETCH_LO: begin
          if (bus_grant) begin
            opcode <= {hi, ram_data};
            op_pc  <= pc;
            state  <= HOLD;
          end
        end
        HOLD, WAIT_CMD: begin
          if (cmd_fire) begin
            if (cmd_err) begin
              stack_err <= 1'b1;
              state     <= HALT;
            end else begin
              pc    <= pc_next;
              state <= FETCH_HI;
            end
          end else if ((state == HOLD) && op_ready) begin
            state <= WAIT_CMD;
          end
        end
        HALT:    state <= HALT;
        default: state <= FETCH_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_fetch.sv
// tb_chip8_fetch
// Self-checking bench for chip8_fetch. The bench acts as the RAM (a 4 KiB byte
// image) and keeps a reference model of pc and the call stack; each issued
// instruction pushes its expected {op_pc, opcode} into a queue that a monitor
// drains whenever the DUT completes an opcode handshake.
module tb_chip8_fetch;

  localparam int STACK_DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_req;
  logic        bus_grant;
  logic [11:0] ram_address;
  logic        ram_select;
  logic        ram_write;
  logic [7:0]  ram_data;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] opcode;
  logic [11:0] op_pc;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [11:0] cmd_target;
  logic [11:0] pc;
  logic        stack_err;

  logic [7:0]  img [4096];
  logic [27:0] expQ [$];
  logic [11:0] stackM [$];
  logic [11:0] pcModel;
  int          checks = 0;
  int          errors = 0;
  bit          randGrant = 1'b0;

  chip8_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .bus_req    (bus_req),
    .bus_grant  (bus_grant),
    .ram_address(ram_address),
    .ram_select (ram_select),
    .ram_write  (ram_write),
    .ram_data   (ram_data),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .opcode     (opcode),
    .op_pc      (op_pc),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_target (cmd_target),
    .pc         (pc),
    .stack_err  (stack_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // The bench is the RAM: asynchronous read of the image.
  assign ram_data = img[ram_address];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (randGrant) bus_grant = ($urandom_range(0, 3) != 0);
  endtask

  // Drains the scoreboard on every cycle that ends in an opcode handshake.
  task automatic monitorLoop();
    logic [27:0] e;
    forever begin
      @(negedge clk);
      if (reset && op_valid && op_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedOpcode", {4'h0, op_pc, opcode}, 32'hFFFF_FFFF);
        end else begin
          e = expQ.pop_front();
          checkOutput("opcode", 32'(opcode), 32'(e[15:0]));
          checkOutput("opPc", 32'(op_pc), 32'(e[27:16]));
        end
      end
    end
  endtask

  task automatic doReset();
    reset      = 1'b0;
    op_ready   = 1'b0;
    cmd_valid  = 1'b0;
    cmd        = 3'd0;
    cmd_target = 12'h000;
    bus_grant  = 1'b1;
    randGrant  = 1'b0;
    tick();
    tick();
    expQ.delete();
    stackM.delete();
    pcModel = 12'h200;
    reset   = 1'b1;
  endtask

  // One instruction: predict it, wait for it, optionally stall the decoder,
  // then hand back the flow command and check the resulting pc.
  task automatic applyStimulus(input logic [2:0] c, input logic [11:0] tgt,
                               input int readyDelay, input bit sameCycle);
    logic [11:0] pcM;
    logic [11:0] pcLo;
    logic [15:0] expOp;
    bit          err;
    int          n;
    pcM   = pcModel;
    pcLo  = pcM + 12'd1;
    expOp = {img[pcM], img[pcLo]};
    expQ.push_back({pcM, expOp});
    err = 1'b0;
    case (c)
      3'd1: pcModel = pcM + 12'd4;
      3'd2: pcModel = tgt;
      3'd3: begin
        if (stackM.size() == STACK_DEPTH) err = 1'b1;
        else begin
          stackM.push_back(pcM + 12'd2);
          pcModel = tgt;
        end
      end
      3'd4: begin
        if (stackM.size() == 0) err = 1'b1;
        else pcModel = stackM.pop_back();
      end
      default: pcModel = pcM + 12'd2;
    endcase

    n = 0;
    while (!op_valid && n < 50) begin
      tick();
      n++;
    end
    checkOutput("opValidRise", 32'(op_valid), 32'd1);

    for (int i = 0; i < readyDelay; i++) begin
      op_ready   = 1'b0;
      cmd_valid  = 1'($urandom_range(0, 1));
      cmd        = 3'($urandom_range(0, 7));
      cmd_target = 12'($urandom);
      tick();
      checkOutput("stallOpcode", 32'(opcode), 32'(expOp));
      checkOutput("stallOpPc", 32'(op_pc), 32'(pcM));
      checkOutput("stallPc", 32'(pc), 32'(pcM));
    end

    op_ready = 1'b1;
    if (sameCycle) begin
      cmd_valid  = 1'b1;
      cmd        = c;
      cmd_target = tgt;
      tick();
    end else begin
      cmd_valid = 1'b0;
      tick();
      op_ready = 1'b0;
      checkOutput("waitCmdOpValid", 32'(op_valid), 32'd0);
      checkOutput("waitCmdPc", 32'(pc), 32'(pcM));
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) tick();
      cmd_valid  = 1'b1;
      cmd        = c;
      cmd_target = tgt;
      tick();
    end
    op_ready  = 1'b0;
    cmd_valid = 1'b0;

    if (err) begin
      checkOutput("stackErr", 32'(stack_err), 32'd1);
      for (int i = 0; i < 3; i++) begin
        checkOutput("haltOpValid", 32'(op_valid), 32'd0);
        checkOutput("haltBusReq", 32'(bus_req), 32'd0);
        checkOutput("haltPc", 32'(pc), 32'(pcM));
        tick();
      end
    end else begin
      checkOutput("cmdPc", 32'(pc), 32'(pcModel));
      checkOutput("fetchAddr", 32'(ram_address), 32'(pcModel));
      checkOutput("noStackErr", 32'(stack_err), 32'd0);
    end
  endtask

  // Main sequence: reset values, directed scenarios, then a randomized run.
  initial begin
    int n;
    logic [2:0] c;
    for (int i = 0; i < 4096; i++) img[12'(i)] = 8'($urandom);
    img[12'h200] = 8'h12;
    img[12'h201] = 8'h4E;
    bus_grant  = 1'b1;
    op_ready   = 1'b0;
    cmd_valid  = 1'b0;
    cmd        = 3'd0;
    cmd_target = 12'h000;
    pcModel    = 12'h200;
    fork
      monitorLoop();
    join_none

    #1 reset = 1'b0;
    #2;
    checkOutput("rstBusReq", 32'(bus_req), 32'd0);
    checkOutput("rstRamSelect", 32'(ram_select), 32'd0);
    checkOutput("rstRamWrite", 32'(ram_write), 32'd0);
    checkOutput("rstRamAddress", 32'(ram_address), 32'h200);
    checkOutput("rstOpValid", 32'(op_valid), 32'd0);
    checkOutput("rstOpcode", 32'(opcode), 32'd0);
    checkOutput("rstOpPc", 32'(op_pc), 32'h200);
    checkOutput("rstPc", 32'(pc), 32'h200);
    checkOutput("rstStackErr", 32'(stack_err), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkOutput("opValidEdge1", 32'(op_valid), 32'd0);
    tick();
    checkOutput("opValidEdge2", 32'(op_valid), 32'd1);

    $display("[TB] directed: jump, stall, skip, call/ret, underflow");
    applyStimulus(3'd2, 12'h24E, 0, 1'b1);
    applyStimulus(3'd0, 12'h000, 5, 1'b1);
    applyStimulus(3'd1, 12'h000, 0, 1'b0);
    applyStimulus(3'd2, 12'h2BE, 0, 1'b1);
    applyStimulus(3'd3, 12'h300, 0, 1'b1);
    applyStimulus(3'd4, 12'h000, 2, 1'b0);
    applyStimulus(3'd4, 12'h000, 0, 1'b1);

    $display("[TB] directed: grant drop between byte reads");
    doReset();
    tick();
    bus_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stallLoAddr", 32'(ram_address), 32'h201);
      checkOutput("stallLoBusReq", 32'(bus_req), 32'd1);
      checkOutput("stallLoSelect", 32'(ram_select), 32'd0);
      checkOutput("stallLoOpValid", 32'(op_valid), 32'd0);
    end
    bus_grant = 1'b1;
    tick();
    checkOutput("stallLoRelease", 32'(op_valid), 32'd1);
    applyStimulus(3'd7, 12'h000, 0, 1'b1);

    $display("[TB] directed: 17 nested calls");
    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(3'd3, 12'($urandom_range(0, 2047) * 2), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end

    $display("[TB] directed: reset while holding an opcode");
    doReset();
    applyStimulus(3'd2, 12'h456, 0, 1'b1);
    n = 0;
    while (!op_valid && n < 10) begin
      tick();
      n++;
    end
    checkOutput("holdBeforeReset", 32'(op_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("asyncRstOpValid", 32'(op_valid), 32'd0);
    checkOutput("asyncRstBusReq", 32'(bus_req), 32'd0);
    checkOutput("asyncRstPc", 32'(pc), 32'h200);
    checkOutput("asyncRstOpcode", 32'(opcode), 32'd0);
    expQ.delete();
    stackM.delete();
    pcModel = 12'h200;
    tick();
    reset = 1'b1;
    applyStimulus(3'd0, 12'h000, 0, 1'b1);
    applyStimulus(3'd2, 12'hFFF, 0, 1'b0);
    applyStimulus(3'd0, 12'h000, 1, 1'b1);

    $display("[TB] randomized run");
    randGrant = 1'b1;
    for (int i = 0; i < 300; i++) begin
      c = 3'($urandom_range(0, 7));
      if (c == 3'd3 && stackM.size() == STACK_DEPTH) c = 3'd0;
      if (c == 3'd4 && stackM.size() == 0) c = 3'd0;
      applyStimulus(c, 12'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    randGrant = 1'b0;
    bus_grant = 1'b1;
    tick();
    tick();
    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
